// File: rtl/frame_sync_bridge_pkg.sv
// Shared types and constants for the frame sync bridge:
// FSM states, default parameters and counter widths.
package frame_bridge_pkg;

    typedef enum logic [1:0] {
        ST_WRITE   = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } bridge_state_e;

    localparam int DEF_NUM_OBJ         = 2;
    localparam int DEF_COORD_W         = 32;
    localparam int DEF_NUM_BTN         = 1;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int FRAME_CNT_W         = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_sync_bridge_if.sv
// CPU-side coordinate write / commit bus of the frame sync bridge.
// The CPU drives writes and commits; the bridge returns frame_ready.
interface frame_sync_bridge_if
    import frame_bridge_pkg::*;
#(
    parameter int NUM_OBJ = DEF_NUM_OBJ,
    parameter int COORD_W = DEF_COORD_W
);
    localparam int IDX_W = idx_width(NUM_OBJ);

    logic               obj_wr_en;
    logic [IDX_W-1:0]   obj_wr_idx;
    logic [COORD_W-1:0] obj_wr_x;
    logic [COORD_W-1:0] obj_wr_y;
    logic               commit;
    logic               frame_ready;

    modport master (
        output obj_wr_en, obj_wr_idx, obj_wr_x, obj_wr_y, commit,
        input  frame_ready
    );

    modport slave (
        input  obj_wr_en, obj_wr_idx, obj_wr_x, obj_wr_y, commit,
        output frame_ready
    );

endinterface

// File: rtl/frame_sync_bridge_button_debouncer.sv
// One button: 2-FF synchroniser, stability counter and level register.
// btn_rise flags the edge on which btn_level goes high.
module button_debouncer
    import frame_bridge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);
    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = level_d & ~level_q;

endmodule

// File: rtl/frame_sync_bridge.sv
// Game CPU / buttons / VGA bridge: debounced sticky buttons and
// double-buffered object coordinates swapped at frame boundaries.
module frame_sync_bridge
    import frame_bridge_pkg::*;
#(
    parameter int NUM_OBJ         = DEF_NUM_OBJ,
    parameter int COORD_W         = DEF_COORD_W,
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_BTN-1:0]           btn_raw,
    input  logic [NUM_BTN-1:0]           btn_ack,
    output logic [NUM_BTN-1:0]           btn_level,
    output logic [NUM_BTN-1:0]           btn_press,
    input  logic                         frame_start,
    frame_sync_bridge_if.slave           cpu,
    output logic [NUM_OBJ*COORD_W-1:0]   active_x,
    output logic [NUM_OBJ*COORD_W-1:0]   active_y,
    output logic [FRAME_CNT_W-1:0]       frame_count,
    output logic [FRAME_CNT_W-1:0]       missed_frames
);
    localparam int IDX_W = idx_width(NUM_OBJ);
    localparam int VEC_W = NUM_OBJ * COORD_W;

    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] press_q, press_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .reset    (reset),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .btn_rise (btn_rise[i])
        );
    end

    // A new rising edge beats a simultaneous acknowledge.
    assign press_d   = (press_q & ~btn_ack) | btn_rise;
    assign btn_press = press_q;

    bridge_state_e            state_q, state_d;
    logic                     ready_q, ready_d;
    logic [VEC_W-1:0]         shx_q, shx_d;
    logic [VEC_W-1:0]         shy_q, shy_d;
    logic [VEC_W-1:0]         actx_q, actx_d;
    logic [VEC_W-1:0]         acty_q, acty_d;
    logic [FRAME_CNT_W-1:0]   fcnt_q, fcnt_d;
    logic [FRAME_CNT_W-1:0]   miss_q, miss_d;

    always_comb begin
        state_d = state_q;
        shx_d   = shx_q;
        shy_d   = shy_q;
        actx_d  = actx_q;
        acty_d  = acty_q;
        fcnt_d  = fcnt_q;
        miss_d  = miss_q;
        unique case (state_q)
            ST_WRITE: begin
                // Out-of-range indices match no slot and are dropped.
                for (int i = 0; i < NUM_OBJ; i++) begin
                    if (cpu.obj_wr_en && cpu.obj_wr_idx == IDX_W'(i)) begin
                        shx_d[i*COORD_W +: COORD_W] = cpu.obj_wr_x;
                        shy_d[i*COORD_W +: COORD_W] = cpu.obj_wr_y;
                    end
                end
                if (cpu.commit && frame_start) begin
                    state_d = ST_SWAP;
                end else if (cpu.commit) begin
                    state_d = ST_PENDING;
                end else if (frame_start && miss_q != '1) begin
                    miss_d = miss_q + 1'b1;
                end
            end
            ST_PENDING: begin
                if (frame_start) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                actx_d  = shx_q;
                acty_d  = shy_q;
                fcnt_d  = fcnt_q + 1'b1;
                state_d = ST_WRITE;
            end
            default: state_d = ST_WRITE;
        endcase
        ready_d = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WRITE;
            ready_q <= 1'b1;
            shx_q   <= '0;
            shy_q   <= '0;
            actx_q  <= '0;
            acty_q  <= '0;
            fcnt_q  <= '0;
            miss_q  <= '0;
            press_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            shx_q   <= shx_d;
            shy_q   <= shy_d;
            actx_q  <= actx_d;
            acty_q  <= acty_d;
            fcnt_q  <= fcnt_d;
            miss_q  <= miss_d;
            press_q <= press_d;
        end
    end

    assign cpu.frame_ready = ready_q;
    assign active_x        = actx_q;
    assign active_y        = acty_q;
    assign frame_count     = fcnt_q;
    assign missed_frames   = miss_q;

endmodule

// File: tb/tb_frame_sync_bridge.sv
// Directed bench for frame_sync_bridge: frame pacing, double buffer,
// combined commit/frame_start, reset discard and button debounce.
module tb_frame_sync_bridge;
    localparam int NOBJ = 3;
    localparam int CW   = 32;
    localparam int NBTN = 2;
    localparam int DEB  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NBTN-1:0]   btn_raw;
    logic [NBTN-1:0]   btn_ack;
    logic [NBTN-1:0]   btn_level;
    logic [NBTN-1:0]   btn_press;
    logic              frame_start;
    logic [NOBJ*CW-1:0] active_x;
    logic [NOBJ*CW-1:0] active_y;
    logic [15:0]       frame_count;
    logic [15:0]       missed_frames;

    int n_pass  = 0;
    int n_total = 0;

    frame_sync_bridge_if #(.NUM_OBJ(NOBJ), .COORD_W(CW)) cpu_if ();

    frame_sync_bridge #(
        .NUM_OBJ(NOBJ), .COORD_W(CW),
        .NUM_BTN(NBTN), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_ack      (btn_ack),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .frame_start  (frame_start),
        .cpu          (cpu_if.slave),
        .active_x     (active_x),
        .active_y     (active_y),
        .frame_count  (frame_count),
        .missed_frames(missed_frames)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [CW-1:0] ax(input int i);
        return active_x[i*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] ay(input int i);
        return active_y[i*CW +: CW];
    endfunction

    task automatic wr(input int idx, input int x, input int y);
        cpu_if.obj_wr_en  = 1'b1;
        cpu_if.obj_wr_idx = 2'(idx);
        cpu_if.obj_wr_x   = CW'(x);
        cpu_if.obj_wr_y   = CW'(y);
        tick();
        cpu_if.obj_wr_en  = 1'b0;
    endtask

    task automatic pulse_commit();
        cpu_if.commit = 1'b1;
        tick();
        cpu_if.commit = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick();
        n_total++;
        if (cpu_if.frame_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cpu_if.frame_ready);
        else n_pass++;
        n_total++;
        if (active_x !== '0 || active_y !== '0) $display("FAIL reset_active got %h/%h want 0", active_x, active_y);
        else n_pass++;
        n_total++;
        if (frame_count !== 16'd0 || missed_frames !== 16'd0)
            $display("FAIL reset_counters got %0d/%0d want 0/0", frame_count, missed_frames);
        else n_pass++;
        n_total++;
        if (btn_level !== 2'b00 || btn_press !== 2'b00)
            $display("FAIL reset_buttons got %b/%b want 00/00", btn_level, btn_press);
        else n_pass++;
    endtask

    task automatic test_missed();
        pulse_fs();
        tick();
        pulse_fs();
        tick();
        n_total++;
        if (missed_frames !== 16'd2) $display("FAIL missed_two got %0d want 2", missed_frames);
        else n_pass++;
        n_total++;
        if (active_x !== '0 || frame_count !== 16'd0)
            $display("FAIL missed_no_swap got %h/%0d want 0/0", active_x, frame_count);
        else n_pass++;
    endtask

    task automatic test_swap();
        wr(0, 100, 200);
        wr(1, 640, 200);
        n_total++;
        if (active_x !== '0) $display("FAIL shadow_hidden got %h want 0", active_x);
        else n_pass++;
        pulse_commit();
        n_total++;
        if (cpu_if.frame_ready !== 1'b0) $display("FAIL commit_ready got %b want 0", cpu_if.frame_ready);
        else n_pass++;
        tick();
        pulse_fs();
        n_total++;
        if (cpu_if.frame_ready !== 1'b0 || ax(0) !== '0)
            $display("FAIL swap_cycle got ready=%b x0=%0d want 0/0", cpu_if.frame_ready, ax(0));
        else n_pass++;
        tick();
        n_total++;
        if (ax(0) !== 100 || ax(1) !== 640 || ay(0) !== 200 || ay(1) !== 200)
            $display("FAIL swap_active got %0d,%0d,%0d,%0d want 100,640,200,200", ax(0), ax(1), ay(0), ay(1));
        else n_pass++;
        n_total++;
        if (cpu_if.frame_ready !== 1'b1 || frame_count !== 16'd1 || missed_frames !== 16'd2)
            $display("FAIL swap_state got ready=%b fc=%0d mf=%0d want 1/1/2",
                     cpu_if.frame_ready, frame_count, missed_frames);
        else n_pass++;
    endtask

    task automatic test_pending_lock();
        pulse_commit();
        cpu_if.commit = 1'b1;
        wr(0, 5, 5);
        cpu_if.commit = 1'b0;
        tick();
        n_total++;
        if (missed_frames !== 16'd2) $display("FAIL pending_no_miss got %0d want 2", missed_frames);
        else n_pass++;
        pulse_fs();
        tick();
        n_total++;
        if (ax(0) !== 100 || ay(0) !== 200 || frame_count !== 16'd2)
            $display("FAIL pending_lock got x0=%0d y0=%0d fc=%0d want 100/200/2", ax(0), ay(0), frame_count);
        else n_pass++;
    endtask

    task automatic test_combined();
        cpu_if.commit = 1'b1;
        frame_start   = 1'b1;
        wr(0, 7, 9);
        cpu_if.commit = 1'b0;
        frame_start   = 1'b0;
        n_total++;
        if (cpu_if.frame_ready !== 1'b0 || ax(0) !== 100)
            $display("FAIL comb_swap_cycle got ready=%b x0=%0d want 0/100", cpu_if.frame_ready, ax(0));
        else n_pass++;
        tick();
        n_total++;
        if (ax(0) !== 7 || ay(0) !== 9 || ax(1) !== 640)
            $display("FAIL comb_active got %0d,%0d,%0d want 7,9,640", ax(0), ay(0), ax(1));
        else n_pass++;
        n_total++;
        if (missed_frames !== 16'd2 || frame_count !== 16'd3 || cpu_if.frame_ready !== 1'b1)
            $display("FAIL comb_state got mf=%0d fc=%0d ready=%b want 2/3/1",
                     missed_frames, frame_count, cpu_if.frame_ready);
        else n_pass++;
    endtask

    task automatic test_buttons();
        int  k;
        bit  seen;
        btn_raw[0] = 1'b1;
        tick(3);
        btn_raw[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (btn_level[0]) seen = 1'b1;
        end
        n_total++;
        if (seen || btn_press[0] !== 1'b0)
            $display("FAIL glitch got rose=%b press=%b want 0/0", seen, btn_press[0]);
        else n_pass++;
        btn_raw[0] = 1'b1;
        k = 0;
        while (btn_level[0] !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_total++;
        if (k < 5 || k > 7) $display("FAIL press_latency got %0d want 6+-1", k);
        else n_pass++;
        n_total++;
        if (btn_press !== 2'b01 || btn_level !== 2'b01)
            $display("FAIL press_flag got press=%b level=%b want 01/01", btn_press, btn_level);
        else n_pass++;
        btn_ack[0] = 1'b1;
        tick();
        btn_ack[0] = 1'b0;
        n_total++;
        if (btn_press[0] !== 1'b0 || btn_level[0] !== 1'b1)
            $display("FAIL ack_clear got press=%b level=%b want 0/1", btn_press[0], btn_level[0]);
        else n_pass++;
        btn_raw[0] = 1'b0;
        k = 0;
        while (btn_level[0] !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        n_total++;
        if (k >= 20 || btn_press[0] !== 1'b0)
            $display("FAIL release got cycles=%0d press=%b want <20/0", k, btn_press[0]);
        else n_pass++;
        btn_raw[0] = 1'b1;
        k = 0;
        btn_ack[0] = 1'b1;
        while (btn_level[0] !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        btn_ack[0] = 1'b0;
        n_total++;
        if (k >= 20 || btn_press[0] !== 1'b1)
            $display("FAIL ack_vs_rise got cycles=%0d press=%b want <20/1", k, btn_press[0]);
        else n_pass++;
    endtask

    task automatic test_reset_pending();
        wr(0, 11, 11);
        pulse_commit();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++;
        if (cpu_if.frame_ready !== 1'b1 || active_x !== '0 || btn_press !== 2'b00)
            $display("FAIL rst_pending got ready=%b ax=%h press=%b want 1/0/00",
                     cpu_if.frame_ready, active_x, btn_press);
        else n_pass++;
        pulse_fs();
        tick();
        n_total++;
        if (frame_count !== 16'd0 || missed_frames !== 16'd1 || active_x !== '0)
            $display("FAIL rst_no_swap got fc=%0d mf=%0d ax=%h want 0/1/0", frame_count, missed_frames, active_x);
        else n_pass++;
        wr(2, 33, 44);
        wr(3, 55, 66);
        pulse_commit();
        pulse_fs();
        tick();
        n_total++;
        if (ax(2) !== 33 || ay(2) !== 44)
            $display("FAIL idx2_write got %0d,%0d want 33,44", ax(2), ay(2));
        else n_pass++;
        n_total++;
        if (ax(0) !== 0 || ay(0) !== 0 || ax(1) !== 0 || ay(1) !== 0 || frame_count !== 16'd1)
            $display("FAIL idx_oob got %0d,%0d,%0d,%0d fc=%0d want 0,0,0,0 fc=1",
                     ax(0), ay(0), ax(1), ay(1), frame_count);
        else n_pass++;
    endtask

    initial begin
        reset             = 1'b1;
        btn_raw           = '0;
        btn_ack           = '0;
        frame_start       = 1'b0;
        cpu_if.obj_wr_en  = 1'b0;
        cpu_if.obj_wr_idx = '0;
        cpu_if.obj_wr_x   = '0;
        cpu_if.obj_wr_y   = '0;
        cpu_if.commit     = 1'b0;
        test_reset();
        test_missed();
        test_swap();
        test_pending_lock();
        test_combined();
        test_buttons();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
